// File: rtl/cpu_out_buffer.sv
// CPU output buffer: captures strobed WIDTH-bit words into a FIFO and
// serializes each word LSB-first onto a valid/ready byte stream.
module cpu_out_buffer #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       outFlag,
    input  logic [WIDTH-1:0]           out,
    output logic [7:0]                 byte_data,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int NBYTES = (WIDTH + 7) / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [8*NBYTES-1:0]   shreg;
    logic [IW-1:0]         idx, idx_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  pop, push, byte_fire;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        pop        = 1'b0;
        byte_fire  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                byte_valid = 1'b1;
                byte_data  = shreg[7:0];
                if (byte_ready) begin
                    byte_fire = 1'b1;
                    if (idx == IW'(NBYTES - 1))
                        state_nxt = IDLE;
                    else
                        idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop on the same edge frees a slot, so a strobe at full is still accepted.
    assign push = outFlag && (!full || pop);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (pop)
                shreg <= (8*NBYTES)'(mem[rd_ptr]);
            else if (byte_fire)
                shreg <= shreg >> 8;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            if (outFlag && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= out;
    end
endmodule

// File: tb/tb_cpu_out_buffer.sv
// Scoreboard bench for cpu_out_buffer: a queue-level model predicts accepted
// words and the expected byte stream; a negedge monitor compares.
module tb_cpu_out_buffer;
    localparam int WIDTH = 36;
    localparam int DEPTH = 16;
    localparam int NB    = 5;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             outFlag = 1'b0;
    logic             byte_ready = 1'b0;
    logic [WIDTH-1:0] out = '0;
    logic [7:0]       byte_data;
    logic             byte_valid, full, empty, overflow;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .outFlag(outFlag), .out(out),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    // model: words waiting in the FIFO, bytes still owed to the sink
    logic [WIDTH-1:0] mq[$];
    logic [7:0]       exp_bytes[$];
    bit               m_send;
    int               m_bidx;
    bit               m_ovf;
    bit               hold_prev;
    logic [7:0]       prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit hs, pp, acc;
        logic [39:0] wx;
        if (reset) begin
            mq.delete();
            exp_bytes.delete();
            m_send = 0; m_bidx = 0; m_ovf = 0; hold_prev = 0;
            chk("rst_valid", byte_valid, 0);
            chk("rst_data", byte_data, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_ovf", overflow, 0);
        end else begin
            chk("count", count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("overflow", overflow, m_ovf);
            chk("valid", byte_valid, m_send);
            if (hold_prev && byte_valid)
                chk("hold", byte_data, prev_data);
            if (byte_valid && byte_ready) begin
                if (exp_bytes.size() == 0)
                    chk("byte_unexpected", 1, 0);
                else
                    chk("byte", byte_data, exp_bytes.pop_front());
            end
            hold_prev = byte_valid && !byte_ready;
            prev_data = byte_data;
            // predict the coming edge
            hs  = m_send && byte_ready;
            pp  = !m_send && mq.size() > 0;
            acc = outFlag && (mq.size() < DEPTH || pp);
            if (outFlag && !acc) m_ovf = 1;
            if (pp) begin
                void'(mq.pop_front());
                m_send = 1; m_bidx = 0;
            end else if (hs) begin
                if (m_bidx == NB - 1) m_send = 0;
                else m_bidx++;
            end
            if (acc) begin
                mq.push_back(out);
                wx = 40'(out);
                for (int i = 0; i < NB; i++) exp_bytes.push_back(8'(wx >> (8 * i)));
            end
        end
    end

    task automatic cyc(input bit f, input logic [WIDTH-1:0] w, input bit r);
        outFlag = f; out = w; byte_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        outFlag = 0; byte_ready = 1;
        while ((!empty || byte_valid) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_done", {empty, byte_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w;
        int n, sent;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (3) cyc(0, '0, 1);

        // single word, ready held high
        cyc(1, 36'h9_8765_4321, 1);
        drain(20);
        chk("t2_empty", empty, 1);
        chk("t2_count", count, 0);

        // backpressure pattern 1,0,0,1,...
        cyc(1, 36'h9_8765_4321, 1);
        for (int i = 0; i < 30 && !(empty && !byte_valid); i++) cyc(0, '0, (i % 3) == 0);
        drain(20);

        // fill past capacity with sink stalled
        for (int i = 1; i <= 18; i++) cyc(1, WIDTH'(i), 0);
        chk("t4_count", count, 16);
        chk("t4_full", full, 1);
        chk("t4_ovf", overflow, 1);
        drain(200);
        chk("t4_ovf_sticky", overflow, 1);

        // push on the same edge as a pop while full
        for (int i = 1; i <= 17; i++) cyc(1, WIDTH'(36'h100 + i), 0);
        outFlag = 0; byte_ready = 1; n = 0;
        while (byte_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("t5_pre_full", full, 1);
        cyc(1, 36'hA_BCDE_F012, 1);
        chk("t5_count", count, 16);
        chk("t5_full", full, 1);
        drain(200);

        // streamed words with random gaps, enough to wrap pointers twice
        sent = 0;
        while (sent < 40) begin
            w = {4'($urandom_range(0, 15)), 32'($urandom)};
            cyc(1, w, 1);
            sent++;
            repeat ($urandom_range(3, 9)) cyc(0, '0, 1);
        end
        drain(400);

        // random strobes and random sink readiness
        for (int i = 0; i < 300; i++) begin
            w = {4'($urandom_range(0, 15)), 32'($urandom)};
            cyc($urandom_range(0, 3) == 0, w, $urandom_range(0, 1) == 1);
        end
        drain(600);

        // async reset mid-cycle, mid-transfer, with words queued
        for (int i = 0; i < 5; i++) cyc(1, WIDTH'(36'h5_0000_0000 + i), 0);
        #2 reset = 1;
        #1;
        chk("t1_valid", byte_valid, 0);
        chk("t1_data", byte_data, 0);
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1);
        chk("t1_full", full, 0);
        chk("t1_ovf", overflow, 0);
        @(posedge clk); #1 reset = 0;
        repeat (4) cyc(0, '0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
